// File: rtl/reglk_pkg.sv
// reglk_pkg: shared state encoding, CTRL bit indices, address offsets and unlock key
package reglk_pkg;
    typedef enum logic [1:0] {
        ST_OPEN        = 2'd0,
        ST_LOCKED      = 2'd1,
        ST_UNLOCK_PEND = 2'd2,
        ST_DEBUG       = 2'd3
    } reglk_state_e;
    localparam int LOCKDOWN_BIT = 0;
    localparam int HIDE_BIT = 1;
    localparam int CTRL_OFS = 0;
    localparam int KEY_OFS = 1;
    localparam int AUDIT_OFS = 2;
    localparam logic [31:0] DEF_UNLOCK_KEY = 32'hA5C3_0F96;
endpackage

// File: rtl/reglk_unlock_fsm.sv
// reglk_unlock_fsm: lockdown/debug-unlock state machine with JTAG edge detect and key window
module reglk_unlock_fsm import reglk_pkg::*; #(
    parameter int DBG_WINDOW = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       key_wr,
    input  logic       key_ok,
    input  logic       lockdown_wr,
    input  logic       jtag_unlock_i,
    output logic [1:0] state,
    output logic       violation
);
    localparam int CW = $clog2(DBG_WINDOW + 1);
    reglk_state_e st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic jtag_q;
    wire jtag_rise = jtag_unlock_i & ~jtag_q;
    assign state = st_q;
    assign violation = key_wr & ~(st_q == ST_UNLOCK_PEND & key_ok);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q <= ST_OPEN;
            cnt_q <= '0;
            jtag_q <= 1'b0;
        end else begin
            st_q <= st_d;
            cnt_q <= cnt_d;
            jtag_q <= jtag_unlock_i;
        end
    end
    // a key write in the window is decided before timeout or JTAG drop
    always_comb begin
        st_d = st_q;
        cnt_d = cnt_q;
        case (st_q)
            ST_OPEN:   if (lockdown_wr) st_d = ST_LOCKED;
            ST_LOCKED: if (jtag_rise) begin
                st_d = ST_UNLOCK_PEND;
                cnt_d = CW'(DBG_WINDOW - 1);
            end
            ST_UNLOCK_PEND: begin
                if (key_wr) st_d = key_ok ? ST_DEBUG : ST_LOCKED;
                else if (!jtag_unlock_i || cnt_q == '0) st_d = ST_LOCKED;
                else cnt_d = cnt_q - 1'b1;
            end
            default:   if (!jtag_unlock_i) st_d = ST_LOCKED;
        endcase
    end
endmodule

// File: rtl/reglk_ctrl_gen2.sv
// reglk_ctrl_gen2: register-lock controller with sticky lockdown and debug-unlock window
// Define REGLK_AUDIT_EN to add the saturating violation counter at NB_PERIPH+2.
module reglk_ctrl_gen2 import reglk_pkg::*; #(
    parameter int          NB_PERIPH  = 14,
    parameter int          LK_WIDTH   = 8,
    parameter int          ADDR_WIDTH = 5,
    parameter int          DATA_WIDTH = 32,
    parameter int          DBG_WINDOW = 16,
    parameter logic [31:0] UNLOCK_KEY = DEF_UNLOCK_KEY
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_i,
    input  logic                          we_i,
    input  logic [ADDR_WIDTH-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    output logic                          rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          err_o,
    input  logic                          jtag_unlock_i,
    output logic [NB_PERIPH*LK_WIDTH-1:0] reglk_ctrl_o,
    output logic [1:0]                    state_o,
    output logic                          locked_o
);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(NB_PERIPH + CTRL_OFS);
    localparam logic [ADDR_WIDTH-1:0] A_KEY = ADDR_WIDTH'(NB_PERIPH + KEY_OFS);
    logic [LK_WIDTH-1:0] lk_q [NB_PERIPH];
    logic [LK_WIDTH-1:0] cur, lk_new;
    logic [1:0] ctrl_q;
    logic [DATA_WIDTH-1:0] rd_d;
    logic err_d, violation;
    wire wr = req_i & we_i;
    wire is_lk = addr_i < ADDR_WIDTH'(NB_PERIPH);
    wire is_ctrl = addr_i == A_CTRL;
    wire is_key = addr_i == A_KEY;
    wire is_open = state_o == ST_OPEN;
    wire locked = state_o == ST_LOCKED || state_o == ST_UNLOCK_PEND;
    wire hidden = ctrl_q[HIDE_BIT] & locked;
    assign locked_o = locked;
`ifdef REGLK_AUDIT_EN
    localparam logic [ADDR_WIDTH-1:0] A_AUD = ADDR_WIDTH'(NB_PERIPH + AUDIT_OFS);
    logic [15:0] aud_q;
    wire is_aud = addr_i == A_AUD;
    always_ff @(posedge clk_i) begin
        if (rst_i) aud_q <= '0;
        else if (req_i && err_d && aud_q != 16'hFFFF) aud_q <= aud_q + 16'd1;
    end
`endif
    reglk_unlock_fsm #(.DBG_WINDOW(DBG_WINDOW)) u_fsm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .key_wr       (wr & is_key),
        .key_ok       (wdata_i == DATA_WIDTH'(UNLOCK_KEY)),
        .lockdown_wr  (wr & is_ctrl & wdata_i[LOCKDOWN_BIT] & is_open),
        .jtag_unlock_i(jtag_unlock_i),
        .state        (state_o),
        .violation    (violation)
    );
    for (genvar i = 0; i < NB_PERIPH; i++) begin : g_out
        assign reglk_ctrl_o[i*LK_WIDTH +: LK_WIDTH] = lk_q[i];
    end
    // while locked, lock words are set-only; clearing attempts are flagged but set bits still land
    always_comb begin
        cur = '0;
        for (int i = 0; i < NB_PERIPH; i++)
            if (addr_i == ADDR_WIDTH'(i)) cur = lk_q[i];
        lk_new = locked ? cur | wdata_i[LK_WIDTH-1:0] : wdata_i[LK_WIDTH-1:0];
        rd_d = '0;
        err_d = 1'b0;
        if (is_lk) begin
            rd_d = hidden ? '0 : DATA_WIDTH'(cur);
            err_d = we_i & locked & |(cur & ~wdata_i[LK_WIDTH-1:0]);
        end else if (is_ctrl) begin
            rd_d = DATA_WIDTH'(ctrl_q);
            err_d = we_i & locked;
        end else if (is_key) begin
            err_d = violation;
`ifdef REGLK_AUDIT_EN
        end else if (is_aud) begin
            rd_d = DATA_WIDTH'(aud_q);
            err_d = we_i;
`endif
        end else begin
            err_d = 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NB_PERIPH; i++) lk_q[i] <= '0;
            ctrl_q <= '0;
            rvalid_o <= 1'b0;
            rdata_o <= '0;
            err_o <= 1'b0;
        end else begin
            for (int i = 0; i < NB_PERIPH; i++)
                if (wr && addr_i == ADDR_WIDTH'(i)) lk_q[i] <= lk_new;
            if (wr && is_ctrl && !locked)
                ctrl_q <= is_open ? wdata_i[1:0] : {wdata_i[HIDE_BIT], ctrl_q[LOCKDOWN_BIT]};
            rvalid_o <= req_i;
            rdata_o <= (req_i && !we_i) ? rd_d : '0;
            err_o <= req_i & err_d;
        end
    end
endmodule

// File: tb/tb_reglk_ctrl_gen2.sv
// tb_reglk_ctrl_gen2: directed plan plus randomized traffic checked against a behavioural model
module tb_reglk_ctrl_gen2;
    localparam logic [31:0] KEY = 32'hA5C3_0F96;
    logic clk = 1'b0, rst, req, we, jtag;
    logic [4:0] addr;
    logic [31:0] wdata, rdata;
    logic rvalid, err, locked;
    logic [111:0] lkvec;
    logic [1:0] state;
    int n_cmp = 0, n_fail = 0;
    bit chk_en = 1'b0;
`ifdef REGLK_AUDIT_EN
    localparam bit AUD = 1'b1;
`else
    localparam bit AUD = 1'b0;
`endif
    reglk_ctrl_gen2 dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .jtag_unlock_i(jtag),
        .reglk_ctrl_o(lkvec), .state_o(state), .locked_o(locked)
    );
    always #5 clk = ~clk;
    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // behavioural model: lock words, CTRL bits, mode, window start cycle, audit count
    logic [7:0] m_lk [14];
    bit m_hide, m_ld, m_jp, m_rv, m_err, m_lkd, m_rise;
    int m_state, m_tp, m_cyc, m_aud, m_ns, m_a;
    logic [31:0] m_rd;
    always @(posedge clk) begin
        m_cyc++;
        if (rst) begin
            foreach (m_lk[i]) m_lk[i] = 8'h00;
            {m_hide, m_ld, m_jp, m_rv, m_err} = '0;
            m_state = 0; m_aud = 0; m_rd = 0;
        end else begin
            m_a = int'(addr);
            m_lkd = (m_state == 1 || m_state == 2);
            m_rise = jtag && !m_jp;
            m_ns = m_state;
            m_err = 1'b0; m_rd = 0;
            if (m_state == 0 && req && we && m_a == 14 && wdata[0]) m_ns = 1;
            if (m_state == 1 && m_rise) begin m_ns = 2; m_tp = m_cyc; end
            if (m_state == 2) begin
                if (req && we && m_a == 15) m_ns = (wdata == KEY) ? 3 : 1;
                else if (!jtag || m_cyc - m_tp == 16) m_ns = 1;
            end
            if (m_state == 3 && !jtag) m_ns = 1;
            if (req) begin
                if (m_a < 14) begin
                    if (we) begin
                        if (m_lkd && (m_lk[m_a] & ~wdata[7:0]) != 0) m_err = 1'b1;
                        m_lk[m_a] = m_lkd ? (m_lk[m_a] | wdata[7:0]) : wdata[7:0];
                    end else m_rd = (m_hide && m_lkd) ? 0 : {24'h0, m_lk[m_a]};
                end else if (m_a == 14) begin
                    if (!we) m_rd = {30'h0, m_hide, m_ld};
                    else if (m_lkd) m_err = 1'b1;
                    else if (m_state == 0) {m_hide, m_ld} = wdata[1:0];
                    else m_hide = wdata[1];
                end else if (m_a == 15) begin
                    if (we) m_err = !(m_state == 2 && wdata == KEY);
                end else if (AUD && m_a == 16) begin
                    if (we) m_err = 1'b1; else m_rd = m_aud;
                end else m_err = 1'b1;
                if (AUD && m_err && m_aud < 65535) m_aud++;
            end
            m_rv = req;
            m_state = m_ns;
            m_jp = jtag;
        end
    end
    always @(negedge clk) if (chk_en) begin
        logic [111:0] ev;
        for (int i = 0; i < 14; i++) ev[i*8 +: 8] = m_lk[i];
        check("rvalid", rvalid, m_rv);
        check("rdata", rdata, m_rd);
        check("err", err, m_err);
        check("state", state, m_state);
        check("locked", locked, m_state == 1 || m_state == 2);
        check("lockvec", lkvec, ev);
    end
    task automatic step(input logic q, input logic w, input logic [4:0] a, input logic [31:0] d);
        req = q; we = w; addr = a; wdata = d;
        @(negedge clk);
    endtask
    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; jtag = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0; chk_en = 1'b1;
        check("rst_state", state, 2'd0);
        check("rst_vec", lkvec, 112'h0);
        check("rst_rvalid", rvalid, 1'b0);
        for (int i = 0; i < 14; i++) begin
            step(1, 0, 5'(i), 0);
            check("rst_word_rd", {rvalid, err, rdata}, {2'b10, 32'h0});
        end
        step(1, 1, 2, 32'h5A); step(1, 1, 2, 32'h00); step(1, 0, 2, 0);
        check("open_clear", {err, rdata}, {1'b0, 32'h0});
        step(1, 1, 14, 1);
        check("lockdown", state, 2'd1);
        step(1, 1, 3, 32'h0F); step(1, 1, 3, 32'hF0); step(1, 0, 3, 0);
        check("sticky_or", {err, rdata}, {1'b0, 32'hFF});
        step(1, 1, 3, 32'h00);
        check("clear_err", err, 1'b1);
        step(1, 0, 3, 0);
        check("clear_kept", rdata, 32'hFF);
        jtag = 1'b1; step(0, 0, 0, 0);
        check("pend", state, 2'd2);
        step(0, 0, 0, 0); step(1, 1, 15, KEY);
        check("debug", state, 2'd3);
        step(1, 1, 3, 0); step(1, 0, 3, 0);
        check("debug_wr", rdata, 32'h0);
        jtag = 1'b0; step(0, 0, 0, 0);
        check("jtag_drop", state, 2'd1);
        step(1, 0, 3, 0);
        check("retained", rdata, 32'h0);
        jtag = 1'b1; step(0, 0, 0, 0);
        for (int k = 1; k < 16; k++) step(0, 0, 0, 0);
        check("window_last", state, 2'd2);
        step(0, 0, 0, 0);
        check("timeout", state, 2'd1);
        jtag = 1'b0; step(0, 0, 0, 0);
        jtag = 1'b1; step(0, 0, 0, 0);
        step(1, 1, 15, 32'h1234_5678);
        check("bad_key", {err, state}, {1'b1, 2'd1});
        jtag = 1'b0; rst = 1'b1; step(0, 0, 0, 0); rst = 1'b0;
        step(1, 1, 0, 32'h33); step(1, 1, 14, 3); step(1, 0, 0, 0);
        check("hidden", {err, rdata}, {1'b0, 32'h0});
        step(1, 0, 14, 0);
        check("ctrl_rd", rdata, 32'h3);
        step(1, 0, 31, 0);
        check("unmapped", {err, rdata}, {1'b1, 32'h0});
`ifdef REGLK_AUDIT_EN
        rst = 1'b1; step(0, 0, 0, 0); rst = 1'b0;
        step(1, 0, 31, 0); step(1, 1, 15, 0); step(1, 1, 16, 0); step(1, 0, 16, 0);
        check("audit3", rdata, 32'd3);
        step(1, 1, 14, 1);
`endif
        jtag = 1'b1; step(0, 0, 0, 0);
        check("pend2", state, 2'd2);
        rst = 1'b1; step(0, 0, 0, 0); rst = 1'b0; jtag = 1'b0;
        check("rst_pend", {state, rvalid, lkvec}, {2'd0, 1'b0, 112'h0});
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [4:0] a;
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 19) == 0) jtag = ~jtag;
            r = $urandom_range(0, 99);
            a = r < 60 ? 5'($urandom_range(0, 13)) : r < 72 ? 5'd14 : r < 84 ? 5'd15 :
                r < 90 ? 5'd16 : 5'($urandom_range(17, 31));
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, a,
                 (a == 15 && $urandom_range(0, 1) == 1) ? KEY : $urandom);
        end
        rst = 1'b0; step(0, 0, 0, 0); step(0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
